// File: rtl/jtcontra_rom_arb.sv
// -----------------------------------------------------------------------------
// jtcontra_rom_arb
// Four-slot SDRAM ROM read arbiter with a one-word cache per slot.
//
// Each slot keeps the last word it fetched together with the address it came
// from. A slot whose current address matches its cached, valid address is
// served from the cache; otherwise it raises a miss. Misses are served one at a
// time through a single outstanding SDRAM read (IDLE -> WAIT_ACK -> WAIT_DATA).
//
// Configuration macro:
//   JTCONTRA_ARB_RR_EN  defined   : round-robin arbitration. The search starts
//                                   at the slot after the last winner.
//                       undefined : fixed priority, slot3 > slot2 > slot1 > slot0.
//
// While downloading is high, every cached entry is invalidated, all ok outputs
// are held low and no new request is issued. A fetch that is already in
// flight still runs to completion, but its data is thrown away.
// -----------------------------------------------------------------------------
module jtcontra_rom_arb #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,

    input  logic          slot0_cs,
    input  logic [AW-1:0] slot0_addr,
    output logic          slot0_ok,
    output logic [DW-1:0] slot0_dout,

    input  logic          slot1_cs,
    input  logic [AW-1:0] slot1_addr,
    output logic          slot1_ok,
    output logic [DW-1:0] slot1_dout,

    input  logic          slot2_cs,
    input  logic [AW-1:0] slot2_addr,
    output logic          slot2_ok,
    output logic [DW-1:0] slot2_dout,

    input  logic          slot3_cs,
    input  logic [AW-1:0] slot3_addr,
    output logic          slot3_ok,
    output logic [DW-1:0] slot3_dout,

    output logic          sdram_req,
    output logic [AW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [DW-1:0] data_read,
    output logic          refresh_en
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_WAIT_DATA
    } state_t;

    // ------------------------------------------------------------------
    // Slot inputs gathered into indexable form
    // ------------------------------------------------------------------
    logic [3:0]    w_cs;
    logic [AW-1:0] w_addr [4];

    assign w_cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign w_addr[0] = slot0_addr;
    assign w_addr[1] = slot1_addr;
    assign w_addr[2] = slot2_addr;
    assign w_addr[3] = slot3_addr;

    // ------------------------------------------------------------------
    // Per-slot cache state
    // ------------------------------------------------------------------
    logic [AW-1:0] r_cache [4];
    logic [DW-1:0] r_dout  [4];
    logic [3:0]    r_valid;
    logic [3:0]    r_ok;

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [1:0]    r_sel;       // slot that owns the current fetch
    logic [AW-1:0] r_lat_addr;  // address of the current fetch, drives sdram_addr
    logic          r_req;
    logic          r_refresh;
    logic          r_discard;   // download seen during this fetch: drop its data

    // ------------------------------------------------------------------
    // Hit / miss detection
    // ------------------------------------------------------------------
    logic [3:0] w_match;
    logic [3:0] w_hit;
    logic [3:0] w_miss;
    logic       w_any_miss;
    logic       w_grant;
    logic [1:0] w_win;
    logic       w_fill;
    logic       w_keep;

    // Compare every slot's current address against its cached entry
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so
        // no path through the block can leave it unassigned and infer a latch.
        w_match = '0;
        for (int n = 0; n < 4; n++) begin
            w_match[n] = r_valid[n] && (w_addr[n] == r_cache[n]);
        end
    end

    assign w_hit      = w_cs & w_match;
    assign w_miss     = w_cs & ~w_match;
    assign w_any_miss = |w_miss;

    // A new fetch may start only from IDLE and never while downloading
    assign w_grant = (r_state == ST_IDLE) && w_any_miss && !downloading;

    // Returned data arrives in WAIT_DATA, or together with the ack in WAIT_ACK
    assign w_fill = data_rdy &&
                    ((r_state == ST_WAIT_DATA) ||
                     ((r_state == ST_WAIT_ACK) && sdram_ack));

    // Data is only cached if no download touched this fetch
    assign w_keep = w_fill && !r_discard && !downloading;

`ifdef JTCONTRA_ARB_RR_EN
    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    logic [1:0] r_rr_ptr;  // last winner

    // Scan from the farthest slot to the nearest; the nearest miss after the
    // last winner overwrites the others and wins
    always_comb begin
        logic [1:0] v_idx;
        w_win = r_rr_ptr;
        v_idx = r_rr_ptr;
        for (int i = 4; i >= 1; i--) begin
            v_idx = r_rr_ptr + 2'(i);
            if (w_miss[v_idx]) begin
                w_win = v_idx;
            end
        end
    end

    // Remember the winner of every grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr <= 2'd0;
        end else if (w_grant) begin
            r_rr_ptr <= w_win;
        end
    end
`else
    // ------------------------------------------------------------------
    // Fixed priority arbitration: higher slot index wins
    // ------------------------------------------------------------------
    // Scan upward so the highest-numbered miss is the last assignment
    always_comb begin
        w_win = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_miss[i]) begin
                w_win = 2'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Request FSM: one outstanding SDRAM read at a time
    // ------------------------------------------------------------------
    // Sequence IDLE -> WAIT_ACK -> WAIT_DATA, with registered request outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= 2'd0;
            r_lat_addr <= '0;
            r_req      <= 1'b0;
            r_refresh  <= 1'b1;
            r_discard  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the values from before this edge, in any order.
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_sel      <= w_win;
                        r_lat_addr <= w_addr[w_win];
                        r_req      <= 1'b1;
                        r_refresh  <= 1'b0;
                        r_discard  <= 1'b0;
                        r_state    <= ST_WAIT_ACK;
                    end else begin
                        // Refresh only when nobody is waiting for data
                        r_refresh  <= !w_any_miss;
                    end
                end

                ST_WAIT_ACK: begin
                    r_refresh <= 1'b0;
                    if (downloading) begin
                        r_discard <= 1'b1;
                    end
                    if (sdram_ack) begin
                        r_req   <= 1'b0;
                        // Ack and data together: treat as ack then data
                        r_state <= data_rdy ? ST_IDLE : ST_WAIT_DATA;
                    end
                end

                ST_WAIT_DATA: begin
                    r_refresh <= 1'b0;
                    if (downloading) begin
                        r_discard <= 1'b1;
                    end
                    if (data_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Cache update and registered ok flags
    // ------------------------------------------------------------------
    // Fill the winner's entry, invalidate on download, register hits as ok
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the per-slot data and address registers are cleared on
            // reset because slotN_dout must read zero afterwards; they are a
            // handful of flops, not a RAM, so this costs only reset fan-out.
            for (int n = 0; n < 4; n++) begin
                r_cache[n] <= '0;
                r_dout[n]  <= '0;
            end
            r_valid <= '0;
            r_ok    <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (downloading) begin
                    r_valid[n] <= 1'b0;
                    r_ok[n]    <= 1'b0;
                end else if (w_keep && (r_sel == 2'(n))) begin
                    r_dout[n]  <= data_read;
                    r_cache[n] <= r_lat_addr;
                    r_valid[n] <= 1'b1;
                    // The requester may have moved on while the fetch ran
                    r_ok[n]    <= w_cs[n] && (w_addr[n] == r_lat_addr);
                end else begin
                    r_ok[n]    <= w_hit[n];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sdram_req  = r_req;
    assign sdram_addr = r_lat_addr;
    assign refresh_en = r_refresh;

    assign slot0_ok   = r_ok[0];
    assign slot1_ok   = r_ok[1];
    assign slot2_ok   = r_ok[2];
    assign slot3_ok   = r_ok[3];

    assign slot0_dout = r_dout[0];
    assign slot1_dout = r_dout[1];
    assign slot2_dout = r_dout[2];
    assign slot3_dout = r_dout[3];

endmodule

// File: tb/tb_jtcontra_rom_arb.sv
// -----------------------------------------------------------------------------
// tb_jtcontra_rom_arb
// Self-checking bench for jtcontra_rom_arb in its default (fixed priority)
// build. Expected SDRAM transactions are queued as stimulus is applied and
// popped when the arbiter issues a request; the bench plays the SDRAM side.
// -----------------------------------------------------------------------------
module tb_jtcontra_rom_arb;

    localparam int AW = 22;
    localparam int DW = 32;

    typedef struct {
        int            slot;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          downloading;
    logic [3:0]    cs;
    logic [AW-1:0] addr [4];
    logic          ok0, ok1, ok2, ok3;
    logic [DW-1:0] dout0, dout1, dout2, dout3;
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          data_rdy;
    logic [DW-1:0] data_read;
    logic          refresh_en;
    logic [3:0]    ok_v;

    int   n_cmp = 0;
    int   n_err = 0;
    req_t exp_q [$];

    assign ok_v = {ok3, ok2, ok1, ok0};

    always #5 clk = ~clk;

    jtcontra_rom_arb #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .slot0_cs    (cs[0]),
        .slot0_addr  (addr[0]),
        .slot0_ok    (ok0),
        .slot0_dout  (dout0),
        .slot1_cs    (cs[1]),
        .slot1_addr  (addr[1]),
        .slot1_ok    (ok1),
        .slot1_dout  (dout1),
        .slot2_cs    (cs[2]),
        .slot2_addr  (addr[2]),
        .slot2_ok    (ok2),
        .slot2_dout  (dout2),
        .slot3_cs    (cs[3]),
        .slot3_addr  (addr[3]),
        .slot3_ok    (ok3),
        .slot3_dout  (dout3),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    function automatic logic [DW-1:0] get_dout(input int s);
        case (s)
            0:       return dout0;
            1:       return dout1;
            2:       return dout2;
            default: return dout3;
        endcase
    endfunction

    // Advance one clock; outputs are stable and inputs may change afterwards
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Play the SDRAM side of one transaction taken from the expected queue
    task automatic serve(input int ack_wait, input int data_wait, input bit dl,
                         input bit chg, input logic [AW-1:0] chg_addr,
                         input logic [DW-1:0] chg_data);
        req_t e;
        req_t c;
        int   n;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL serve_queue: no expected transaction queued");
            return;
        end
        e = exp_q.pop_front();
        n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        n_cmp++;
        if (sdram_req !== 1'b1) begin
            n_err++;
            $display("FAIL req_timeout: sdram_req=%b required 1 for addr %h", sdram_req, e.addr);
            return;
        end
        n_cmp++;
        if (sdram_addr !== e.addr) begin
            n_err++;
            $display("FAIL req_addr: sdram_addr=%h required %h", sdram_addr, e.addr);
        end
        n_cmp++;
        if (refresh_en !== 1'b0) begin
            n_err++;
            $display("FAIL refresh_busy: refresh_en=%b required 0", refresh_en);
        end
        repeat (ack_wait) tick();
        n_cmp++;
        if (sdram_req !== 1'b1 || sdram_addr !== e.addr) begin
            n_err++;
            $display("FAIL req_hold: req=%b addr=%h required 1 %h", sdram_req, sdram_addr, e.addr);
        end
        sdram_ack = 1'b1;
        if (data_wait == 0) begin
            data_rdy  = 1'b1;
            data_read = e.data;
        end
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        n_cmp++;
        if (sdram_req !== 1'b0) begin
            n_err++;
            $display("FAIL req_drop: sdram_req=%b required 0 after ack", sdram_req);
        end
        if (data_wait == 0) return;
        if (chg) begin
            addr[e.slot] = chg_addr;
            c.slot = e.slot;
            c.addr = chg_addr;
            c.data = chg_data;
            exp_q.push_back(c);
        end
        if (dl) begin
            downloading = 1'b1;
            tick();
            n_cmp++;
            if (ok_v !== 4'b0000) begin
                n_err++;
                $display("FAIL dl_ok: ok=%b required 0000", ok_v);
            end
            data_rdy  = 1'b1;
            data_read = e.data;
            tick();
            data_rdy  = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                n_cmp++;
                if (sdram_req !== 1'b0 || ok_v !== 4'b0000) begin
                    n_err++;
                    $display("FAIL dl_block: req=%b ok=%b required 0 0000", sdram_req, ok_v);
                end
            end
            downloading = 1'b0;
            return;
        end
        repeat (data_wait - 1) tick();
        data_rdy  = 1'b1;
        data_read = e.data;
        tick();
        data_rdy  = 1'b0;
        n_cmp++;
        if (get_dout(e.slot) !== e.data) begin
            n_err++;
            $display("FAIL fill_dout: slot%0d dout=%h required %h", e.slot, get_dout(e.slot), e.data);
        end
    endtask

    task automatic push_req(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t e;
        e.slot = s;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (sdram_req !== 1'b0 || sdram_addr !== '0) begin
            n_err++;
            $display("FAIL %s_req: req=%b addr=%h required 0 0", tag, sdram_req, sdram_addr);
        end
        n_cmp++;
        if (ok_v !== 4'b0000) begin
            n_err++;
            $display("FAIL %s_ok: ok=%b required 0000", tag, ok_v);
        end
        n_cmp++;
        if ({dout3, dout2, dout1, dout0} !== '0) begin
            n_err++;
            $display("FAIL %s_dout: dout=%h %h %h %h required 0", tag, dout3, dout2, dout1, dout0);
        end
        n_cmp++;
        if (refresh_en !== 1'b1) begin
            n_err++;
            $display("FAIL %s_refresh: refresh_en=%b required 1", tag, refresh_en);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; downloading = 1'b0; cs = 4'b0000;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        for (int i = 0; i < 4; i++) addr[i] = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
    endtask

    // slot3 miss, ack two cycles later, data four cycles after ack
    task automatic test_fill();
        cs[3] = 1'b1; addr[3] = 22'h01000;
        push_req(3, 22'h01000, 32'hDEADBEEF);
        serve(2, 4, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (ok3 !== 1'b1) begin
            n_err++;
            $display("FAIL fill_ok3: ok3=%b required 1", ok3);
        end
    endtask

    // Repeat access to the filled address is served from the cache
    task automatic test_hit();
        tick();
        n_cmp++;
        if (ok3 !== 1'b1 || sdram_req !== 1'b0 || refresh_en !== 1'b1) begin
            n_err++;
            $display("FAIL hit: ok3=%b req=%b refresh=%b required 1 0 1", ok3, sdram_req, refresh_en);
        end
        cs[3] = 1'b0;
        tick();
        n_cmp++;
        if (ok3 !== 1'b0) begin
            n_err++;
            $display("FAIL hit_cs_low: ok3=%b required 0", ok3);
        end
        cs[3] = 1'b1;
        tick();
        n_cmp++;
        if (ok3 !== 1'b1 || sdram_req !== 1'b0) begin
            n_err++;
            $display("FAIL hit_again: ok3=%b req=%b required 1 0", ok3, sdram_req);
        end
    endtask

    // Simultaneous slot0/slot2 misses: slot2 first, then slot0
    task automatic test_priority();
        cs[0] = 1'b1; addr[0] = 22'h00200;
        cs[2] = 1'b1; addr[2] = 22'h00300;
        push_req(2, 22'h00300, 32'h22223333);
        push_req(0, 22'h00200, 32'h00002222);
        serve(1, 2, 1'b0, 1'b0, '0, '0);
        serve(0, 1, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (ok_v !== 4'b1101) begin
            n_err++;
            $display("FAIL priority_ok: ok=%b required 1101", ok_v);
        end
    endtask

    // slot1 moves 0x100 -> 0x104 during WAIT_DATA
    task automatic test_addr_change();
        cs = 4'b0010; addr[1] = 22'h00100;
        push_req(1, 22'h00100, 32'h11110100);
        serve(1, 3, 1'b0, 1'b1, 22'h00104, 32'h11110104);
        n_cmp++;
        if (ok1 !== 1'b0) begin
            n_err++;
            $display("FAIL chg_ok1: ok1=%b required 0", ok1);
        end
        serve(1, 2, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (ok1 !== 1'b1) begin
            n_err++;
            $display("FAIL chg_refetch_ok1: ok1=%b required 1", ok1);
        end
    endtask

    // downloading during WAIT_DATA invalidates everything and drops the data
    task automatic test_download();
        cs = 4'b1101;
        addr[3] = 22'h01000; addr[0] = 22'h00200; addr[2] = 22'h00500;
        push_req(2, 22'h00500, 32'h55550000);
        serve(1, 2, 1'b1, 1'b0, '0, '0);
        push_req(3, 22'h01000, 32'hDEADBEEF);
        push_req(2, 22'h00500, 32'h55550001);
        push_req(0, 22'h00200, 32'h00002223);
        serve(0, 1, 1'b0, 1'b0, '0, '0);
        serve(1, 1, 1'b0, 1'b0, '0, '0);
        serve(2, 2, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (ok_v !== 4'b1101) begin
            n_err++;
            $display("FAIL dl_refill_ok: ok=%b required 1101", ok_v);
        end
    endtask

    // ack and data_rdy in the same cycle
    task automatic test_back_to_back();
        cs = 4'b0010; addr[1] = 22'h00700;
        push_req(1, 22'h00700, 32'hA5A5_0700);
        serve(1, 0, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (ok1 !== 1'b1 || dout1 !== 32'hA5A5_0700) begin
            n_err++;
            $display("FAIL ackdata: ok1=%b dout1=%h required 1 a5a50700", ok1, dout1);
        end
    endtask

    // Reset during WAIT_ACK abandons the fetch; late data_rdy is ignored
    task automatic test_reset_mid();
        cs = 4'b0100; addr[2] = 22'h00900;
        tick();
        n_cmp++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h00900) begin
            n_err++;
            $display("FAIL rmid_req: req=%b addr=%h required 1 000900", sdram_req, sdram_addr);
        end
        tick();
        rst = 1'b0; cs = 4'b0000;
        tick();
        check_reset_outputs("rmid");
        rst = 1'b1;
        data_rdy = 1'b1; data_read = 32'hBAD0BAD0;
        tick();
        data_rdy = 1'b0;
        tick();
        n_cmp++;
        if (sdram_req !== 1'b0 || ok_v !== 4'b0000 || dout2 !== '0) begin
            n_err++;
            $display("FAIL rmid_late_data: req=%b ok=%b dout2=%h required 0 0000 0", sdram_req, ok_v, dout2);
        end
        cs[2] = 1'b1;
        push_req(2, 22'h00900, 32'h99990900);
        serve(1, 1, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (ok2 !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_refetch_ok2: ok2=%b required 1", ok2);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hit();
        test_priority();
        test_addr_change();
        test_download();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: %0d transactions left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
